// File: rtl/aiv_sync_generator.sv
// AIV sync generator: 625-line interlaced PAL timing source.
// Divides clk down to the dot rate and runs dot/line/field counters.
// Decodes hsync, vsync, field, active-frame coordinates, display enable
// and the frame start pulse from those counters into registered outputs.
module aiv_sync_generator #(
    parameter int CLK_DIV        = 6,
    parameter int H_TOTAL        = 864,
    parameter int H_SYNC_WIDTH   = 64,
    parameter int H_ACTIVE_START = 72,
    parameter int H_ACTIVE       = 720,
    parameter int V_ODD_LINES    = 312,
    parameter int V_EVEN_LINES   = 313,
    parameter int V_SYNC_LINES   = 3,
    parameter int V_ACTIVE_START = 23,
    parameter int V_ACTIVE       = 288
) (
    input  logic       clk,
    input  logic       nReset,
    input  logic       enable,
    output logic       dot_ce,
    output logic       hsync,
    output logic       vsync,
    output logic       isFieldOdd,
    output logic [9:0] active_frame_dot,
    output logic [9:0] active_frame_line,
    output logic       display_enable,
    output logic       frame_start_flag
);

    localparam int CDW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    localparam logic [CDW-1:0] DIV_LAST    = CDW'(CLK_DIV - 1);
    localparam logic [CDW-1:0] DIV_ONE     = CDW'(1);
    localparam logic [9:0]     H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0]     H_SYNC_END  = 10'(H_SYNC_WIDTH);
    localparam logic [9:0]     H_AS        = 10'(H_ACTIVE_START);
    localparam logic [9:0]     H_AE        = 10'(H_ACTIVE_START + H_ACTIVE);
    localparam logic [9:0]     V_ODD_LAST  = 10'(V_ODD_LINES - 1);
    localparam logic [9:0]     V_EVEN_LAST = 10'(V_EVEN_LINES - 1);
    localparam logic [9:0]     V_SYNC_END  = 10'(V_SYNC_LINES);
    localparam logic [9:0]     V_AS        = 10'(V_ACTIVE_START);
    localparam logic [9:0]     V_AE        = 10'(V_ACTIVE_START + V_ACTIVE);

    // Divider and timing counter state
    logic [CDW-1:0] clk_div_r;
    logic           dot_ce_r;
    logic           upd_r;
    logic [9:0]     dot_r;
    logic [9:0]     line_r;
    logic           field_odd_r;

    // Counter next-state
    logic [9:0]     dot_nxt_s;
    logic [9:0]     line_nxt_s;
    logic           field_nxt_s;
    logic [9:0]     field_last_s;

    // Decoded timing (combinational, from current counters)
    logic           hsync_s;
    logic           vsync_s;
    logic           active_s;
    logic [9:0]     afd_s;
    logic [9:0]     afl_s;
    logic           fs_s;

    // Decoded timing registers
    logic           hsync_r;
    logic           vsync_r;
    logic           field_out_r;
    logic           de_r;
    logic [9:0]     afd_r;
    logic [9:0]     afl_r;
    logic           fs_r;

    // Dot-rate divider; upd_r marks the clk right after the counters moved
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            clk_div_r <= {CDW{1'b0}};
            dot_ce_r  <= 1'b0;
            upd_r     <= 1'b0;
        end else if (!enable) begin
            clk_div_r <= {CDW{1'b0}};
            dot_ce_r  <= 1'b0;
            upd_r     <= 1'b0;
        end else begin
            upd_r <= dot_ce_r;
            if (clk_div_r == DIV_LAST) begin
                clk_div_r <= {CDW{1'b0}};
                dot_ce_r  <= 1'b1;
            end else begin
                clk_div_r <= clk_div_r + DIV_ONE;
                dot_ce_r  <= 1'b0;
            end
        end
    end

    // Dot/line/field next-state; field length depends on which field is running
    always_comb begin
        dot_nxt_s    = dot_r;
        line_nxt_s   = line_r;
        field_nxt_s  = field_odd_r;
        field_last_s = field_odd_r ? V_ODD_LAST : V_EVEN_LAST;
        if (dot_ce_r) begin
            if (dot_r == H_LAST) begin
                dot_nxt_s = 10'd0;
                if (line_r == field_last_s) begin
                    line_nxt_s  = 10'd0;
                    field_nxt_s = ~field_odd_r;
                end else begin
                    line_nxt_s  = line_r + 10'd1;
                    field_nxt_s = field_odd_r;
                end
            end else begin
                dot_nxt_s = dot_r + 10'd1;
            end
        end else begin
            dot_nxt_s = dot_r;
        end
    end

    // Counter state registers; the field starts odd
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            dot_r       <= 10'd0;
            line_r      <= 10'd0;
            field_odd_r <= 1'b1;
        end else if (!enable) begin
            dot_r       <= 10'd0;
            line_r      <= 10'd0;
            field_odd_r <= 1'b1;
        end else begin
            dot_r       <= dot_nxt_s;
            line_r      <= line_nxt_s;
            field_odd_r <= field_nxt_s;
        end
    end

    // Timing decode from counter state; coordinates forced to 0 outside active
    always_comb begin
        hsync_s  = (dot_r < H_SYNC_END);
        vsync_s  = (line_r < V_SYNC_END);
        active_s = (dot_r >= H_AS) && (dot_r < H_AE) &&
                   (line_r >= V_AS) && (line_r < V_AE);
        if (active_s) begin
            afd_s = dot_r - H_AS;
            afl_s = ((line_r - V_AS) << 1) + {9'd0, field_odd_r};
        end else begin
            afd_s = 10'd0;
            afl_s = 10'd0;
        end
        fs_s = upd_r && field_odd_r && (dot_r == H_AS) && (line_r == V_AS);
    end

    // Output registers, one clk behind the counters
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            hsync_r     <= 1'b0;
            vsync_r     <= 1'b0;
            field_out_r <= 1'b1;
            de_r        <= 1'b0;
            afd_r       <= 10'd0;
            afl_r       <= 10'd0;
            fs_r        <= 1'b0;
        end else if (!enable) begin
            hsync_r     <= 1'b0;
            vsync_r     <= 1'b0;
            field_out_r <= 1'b1;
            de_r        <= 1'b0;
            afd_r       <= 10'd0;
            afl_r       <= 10'd0;
            fs_r        <= 1'b0;
        end else begin
            hsync_r     <= hsync_s;
            vsync_r     <= vsync_s;
            field_out_r <= field_odd_r;
            de_r        <= active_s;
            afd_r       <= afd_s;
            afl_r       <= afl_s;
            fs_r        <= fs_s;
        end
    end

    assign dot_ce            = dot_ce_r;
    assign hsync             = hsync_r;
    assign vsync             = vsync_r;
    assign isFieldOdd        = field_out_r;
    assign display_enable    = de_r;
    assign active_frame_dot  = afd_r;
    assign active_frame_line = afl_r;
    assign frame_start_flag  = fs_r;

endmodule
